sram_1rw1r_model: RTL and testbench

- Parametrised behavioural SRAM model with two ports on a single clock.
- Port 0 is read/write with a byte write mask. Port 1 is read-only.
- Replaces the single-port 1RW model used as DUT/reference memory in the UVM environment.
- Adds: configurable read latency, read-valid strobes, out-of-range detection, and optional same-address collision detection.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_rd_pipe.sv | 80 ++++++++
 rtl/sram_1rw1r_model.sv | 149 ++++++++++++++
 tb/tb_sram_1rw1r_model.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the 1RW/1R SRAM model.
//   - SRAM_DATA_WIDTH / SRAM_ADDR_WIDTH : default word and address widths
//   - word_t / addr_t / wmask_t         : word, address and byte-mask types
//   - bytes_of(width)                   : number of byte lanes in a word
// No ports (package).
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 32'd32;
  localparam int unsigned SRAM_ADDR_WIDTH = 32'd8;

  typedef logic [SRAM_DATA_WIDTH-1:0]      word_t;
  typedef logic [SRAM_ADDR_WIDTH-1:0]      addr_t;
  typedef logic [SRAM_DATA_WIDTH/8-1:0]    wmask_t;

  // Byte lanes in a word of the given bit width (width is a multiple of 8).
  function automatic int unsigned bytes_of(input int unsigned width);
    return width / 32'd8;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_pipe
// LATENCY-deep read-result pipeline carrying {data, vld, flag}.
// Each stage only loads new data when the incoming valid is set, so the last
// stage (the port output) holds its previous word between read results.
// Ports:
//   clk_i   in  clock
//   clr_i   in  synchronous clear of every stage (data, vld, flag)
//   vld_i   in  read accepted this edge
//   data_i  in  word sampled this edge
//   flag_i  in  side-band flag travelling with the read (qualified by vld_i)
//   vld_o   out one-cycle strobe, data_o carries new read data
//   data_o  out read data (held while vld_o is 0)
//   flag_o  out flag aligned with vld_o
// -----------------------------------------------------------------------------
module sram_rd_pipe #(
  parameter int unsigned WIDTH   = 32'd32,
  parameter int unsigned LATENCY = 32'd1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             flag_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic             flag_o
);

  logic [LATENCY-1:0]            vld_q, vld_d, flag_q, flag_d;
  logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;

  // Per-stage source: stage 0 is fed from the inputs, stage g from stage g-1.
  logic [LATENCY-1:0]            src_vld_s, src_flag_s;
  logic [LATENCY-1:0][WIDTH-1:0] src_data_s;

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign src_vld_s[g]  = vld_i;
      assign src_flag_s[g] = flag_i & vld_i;
      assign src_data_s[g] = data_i;
    end else begin : g_rest
      assign src_vld_s[g]  = vld_q[g-1];
      assign src_flag_s[g] = flag_q[g-1];
      assign src_data_s[g] = data_q[g-1];
    end
  end

  // Next-state: shift valid/flag every cycle, load data only with a valid.
  always_comb begin
    vld_d  = src_vld_s;
    flag_d = src_flag_s;
    data_d = data_q;
    for (int i = 0; i < int'(LATENCY); i++) begin
      if (src_vld_s[i]) begin
        data_d[i] = src_data_s[i];
      end else begin
        data_d[i] = data_q[i];
      end
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q  <= '0;
      flag_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      flag_q <= flag_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q[LATENCY-1];
  assign flag_o = flag_q[LATENCY-1];
  assign data_o = data_q[LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_model.sv
// -----------------------------------------------------------------------------
// sram_1rw1r_model
// Behavioural two-port SRAM: port 0 read/write with byte mask, port 1 read-only.
// Reads are fully pipelined with READ_LATENCY cycles to data, each result
// marked by a one-cycle vld strobe. Addresses >= DEPTH drop writes, read as 0
// and raise a one-cycle addr_err pulse.
// Optional build macro: SRAM_COLLISION_DET_EN -- flags a port 1 read of the
// address port 0 writes (non-zero mask) on the same edge; otherwise collision=0.
// Ports:
//   clk0       in  clock (rising edge)
//   rst0       in  synchronous active-high reset (memory contents kept)
//   csb0/web0  in  port 0 chip select / write enable, both active-low
//   wmask0     in  port 0 byte write mask
//   addr0/din0 in  port 0 address / write data
//   dout0      out port 0 read data, dout0_vld strobe
//   csb1/addr1 in  port 1 chip select (active-low) / address
//   dout1      out port 1 read data, dout1_vld strobe
//   addr_err   out pulse one cycle after an out-of-range accepted access
//   collision  out same-address write/read flag aligned with dout1_vld
// -----------------------------------------------------------------------------
module sram_1rw1r_model
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = SRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = SRAM_ADDR_WIDTH,
  parameter int unsigned DEPTH        = (32'd1 << ADDR_WIDTH),
  parameter int unsigned READ_LATENCY = 32'd1
) (
  input  logic                    clk0,
  input  logic                    rst0,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [DATA_WIDTH/8-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   din0,
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic                    dout0_vld,
  input  logic                    csb1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  output logic [DATA_WIDTH-1:0]   dout1,
  output logic                    dout1_vld,
  output logic                    addr_err,
  output logic                    collision
);

  localparam int unsigned           NB      = bytes_of(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic acc_rd0_s, acc_wr0_s, acc_rd1_s;
  logic in_rng0_s, in_rng1_s;
  logic err_d, err_q;
  logic coll_s;
  logic p0_flag_unused_s;
  logic [DATA_WIDTH-1:0] rdata0_s, rdata1_s;

  // Accesses during reset are ignored entirely.
  assign acc_rd0_s = ~rst0 & ~csb0 & web0;
  assign acc_wr0_s = ~rst0 & ~csb0 & ~web0;
  assign acc_rd1_s = ~rst0 & ~csb1;
  assign in_rng0_s = ({1'b0, addr0} < DEPTH_W);
  assign in_rng1_s = ({1'b0, addr1} < DEPTH_W);

  // Array read at the edge; mem_q still holds the pre-write word, which gives
  // read-before-write on a same-address port 0 write / port 1 read.
  always_comb begin
    rdata0_s = '0;
    rdata1_s = '0;
    if (in_rng0_s) begin
      rdata0_s = mem_q[addr0];
    end else begin
      rdata0_s = '0;
    end
    if (in_rng1_s) begin
      rdata1_s = mem_q[addr1];
    end else begin
      rdata1_s = '0;
    end
  end

  // Masked byte write; the array is deliberately not reset.
  always_ff @(posedge clk0) begin
    if (acc_wr0_s && in_rng0_s) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wmask0[b]) begin
          mem_q[addr0][8*b +: 8] <= din0[8*b +: 8];
        end
      end
    end
  end

  // Either port out of range collapses into one error pulse.
  assign err_d = ((acc_rd0_s | acc_wr0_s) & ~in_rng0_s) | (acc_rd1_s & ~in_rng1_s);

  // Error pulse register.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

`ifdef SRAM_COLLISION_DET_EN
  assign coll_s = acc_wr0_s & acc_rd1_s & (addr0 == addr1) & (|wmask0);

  // Simulation notice for same-edge write/read of one address.
  always_ff @(posedge clk0) begin
    if (coll_s) begin
      $warning("sram collision: port0 write addr %0h, port1 read addr %0h at %0t",
               addr0, addr1, $time);
    end
  end
`else
  assign coll_s = 1'b0;
`endif

  sram_rd_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_pipe0 (
    .clk_i  (clk0),
    .clr_i  (rst0),
    .vld_i  (acc_rd0_s),
    .data_i (rdata0_s),
    .flag_i (1'b0),
    .vld_o  (dout0_vld),
    .data_o (dout0),
    .flag_o (p0_flag_unused_s)
  );

  sram_rd_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_pipe1 (
    .clk_i  (clk0),
    .clr_i  (rst0),
    .vld_i  (acc_rd1_s),
    .data_i (rdata1_s),
    .flag_i (coll_s),
    .vld_o  (dout1_vld),
    .data_o (dout1),
    .flag_o (collision)
  );

  assign addr_err = err_q;

endmodule

// File: tb/tb_sram_1rw1r_model.sv
// -----------------------------------------------------------------------------
// tb_sram_1rw1r_model
// Self-checking bench: directed vector table, hand sequences for streaming and
// reset flush, then randomized traffic checked cycle by cycle against a
// reference memory plus a per-cycle schedule of expected read results.
// -----------------------------------------------------------------------------
module tb_sram_1rw1r_model;
  import sram_pkg::*;

  localparam int unsigned DEPTH = 200;
  localparam int unsigned RL    = 3;
  localparam int          MAXC  = 4096;
`ifdef SRAM_COLLISION_DET_EN
  localparam bit COLL_ON = 1'b1;
`else
  localparam bit COLL_ON = 1'b0;
`endif

  logic   clk0 = 1'b0;
  logic   rst0, csb0, web0, csb1;
  wmask_t wmask0;
  addr_t  addr0, addr1;
  word_t  din0, dout0, dout1;
  logic   dout0_vld, dout1_vld, addr_err, collision;

  sram_1rw1r_model #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (8),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .clk0      (clk0),
    .rst0      (rst0),
    .csb0      (csb0),
    .web0      (web0),
    .wmask0    (wmask0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0),
    .dout0_vld (dout0_vld),
    .csb1      (csb1),
    .addr1     (addr1),
    .dout1     (dout1),
    .dout1_vld (dout1_vld),
    .addr_err  (addr_err),
    .collision (collision)
  );

  always #5 clk0 = ~clk0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: memory contents and, per edge number, the read result
  // that becomes visible after that edge.
  word_t m_mem [DEPTH];
  bit    s0_v [MAXC];
  bit    s1_v [MAXC];
  bit    s1_c [MAXC];
  word_t s0_d [MAXC];
  word_t s1_d [MAXC];
  word_t e_d0 = '0, e_d1 = '0;
  bit    e_v0 = 1'b0, e_v1 = 1'b0, e_err = 1'b0, e_col = 1'b0;

  typedef struct {
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic        e_err;
    logic        e_coll;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0;
    addr0 = 8'h00; din0 = 32'h0; csb1 = 1'b1; addr1 = 8'h00;
  endtask

  task automatic model_edge();
    int idx;
    bit rd0, wr, rd1, ok0, ok1;
    idx = cyc + int'(RL) - 1;
    if (rst0) begin
      for (int j = cyc; j < MAXC; j++) begin
        s0_v[j] = 1'b0; s1_v[j] = 1'b0; s1_c[j] = 1'b0;
      end
      e_d0 = '0; e_d1 = '0; e_v0 = 1'b0; e_v1 = 1'b0; e_err = 1'b0; e_col = 1'b0;
    end else begin
      rd0 = !csb0 && web0;
      wr  = !csb0 && !web0;
      rd1 = !csb1;
      ok0 = (int'(addr0) < int'(DEPTH));
      ok1 = (int'(addr1) < int'(DEPTH));
      e_err = ((rd0 || wr) && !ok0) || (rd1 && !ok1);
      if (rd0) begin
        s0_v[idx] = 1'b1;
        s0_d[idx] = ok0 ? m_mem[addr0] : 32'h0;
      end
      if (rd1) begin
        s1_v[idx] = 1'b1;
        s1_d[idx] = ok1 ? m_mem[addr1] : 32'h0;
        s1_c[idx] = COLL_ON && wr && (addr0 == addr1) && (wmask0 != 4'h0);
      end
      if (wr && ok0) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask0[b]) m_mem[addr0][8*b +: 8] = din0[8*b +: 8];
        end
      end
      e_v0 = s0_v[cyc];
      if (e_v0) e_d0 = s0_d[cyc];
      e_v1 = s1_v[cyc];
      if (e_v1) e_d1 = s1_d[cyc];
      e_col = e_v1 && s1_c[cyc];
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk0);
    model_edge();
    cyc++;
    #1;
    chk("dout0_vld", dout0_vld, e_v0);
    chk("dout0",     dout0,     e_d0);
    chk("dout1_vld", dout1_vld, e_v1);
    chk("dout1",     dout1,     e_d1);
    chk("addr_err",  addr_err,  e_err);
    chk("collision", collision, e_col);
  endtask

  initial begin
    // csb0 web0 wmask addr0 din0 csb1 addr1 exp_dout0 exp_dout1 err coll
    tbl[0]  = '{1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0,        1'b1, 8'h00, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'hF, 8'h05, 32'h11223344, 1'b1, 8'h00, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'h5, 8'h05, 32'hAABBCCDD, 1'b1, 8'h00, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h05, 32'h0,        32'h11BB33DD, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'hF, 8'h07, 32'h0,        1'b1, 8'h00, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'hF, 8'h07, 32'hFFFFFFFF, 1'b0, 8'h07, 32'h0,        32'h00000000, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0,        1'b0, 8'h07, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 8'h32, 32'h50505050, 1'b1, 8'h00, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'hF, 8'hC7, 32'hCAFEF00D, 1'b1, 8'h00, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'hF, 8'hFA, 32'h12345678, 1'b1, 8'h00, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 8'hFA, 32'h0,        1'b1, 8'h00, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 8'hFA, 32'h0,        1'b0, 8'hFB, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 8'h32, 32'h0,        1'b0, 8'hC7, 32'h50505050, 32'hCAFEF00D, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 8'h10, 32'h0,        1'b1, 8'h00, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0,        1'b1, 8'h00, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};

    // Reset state
    idle();
    rst0 = 1'b1;
    step();
    step();
    chk("reset_dout0", dout0, 32'h0);
    chk("reset_vld1",  dout1_vld, 1'b0);
    idle();

    // Fill every implemented word so model and DUT agree on contents
    for (int a = 0; a < int'(DEPTH); a++) begin
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'(a); din0 = $urandom;
      step();
    end
    idle();

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      csb0 = tbl[i].csb0; web0 = tbl[i].web0; wmask0 = tbl[i].wmask0;
      addr0 = tbl[i].addr0; din0 = tbl[i].din0; csb1 = tbl[i].csb1; addr1 = tbl[i].addr1;
      step();
      chk($sformatf("tbl%0d_err", i), addr_err, tbl[i].e_err);
      idle();
      repeat (RL - 1) step();
      if (!tbl[i].csb0 && tbl[i].web0) begin
        chk($sformatf("tbl%0d_vld0", i),  dout0_vld, 1'b1);
        chk($sformatf("tbl%0d_dout0", i), dout0, tbl[i].e_d0);
      end
      if (!tbl[i].csb1) begin
        chk($sformatf("tbl%0d_vld1", i),  dout1_vld, 1'b1);
        chk($sformatf("tbl%0d_dout1", i), dout1, tbl[i].e_d1);
        chk($sformatf("tbl%0d_coll", i),  collision, tbl[i].e_coll & COLL_ON);
      end
    end

    // Streaming: 8 back-to-back reads, 8 consecutive pulses in address order
    for (int a = 0; a < 8; a++) begin
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'(a); din0 = 32'hA0000000 + a;
      step();
    end
    idle();
    for (int j = 0; j < 14; j++) begin
      if (j < 8) begin
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'(j);
      end else begin
        idle();
      end
      step();
      if (j >= int'(RL) - 1 && j < int'(RL) - 1 + 8) begin
        chk($sformatf("stream%0d_vld", j), dout0_vld, 1'b1);
        chk($sformatf("stream%0d_data", j), dout0, 32'hA0000000 + j - (int'(RL) - 1));
      end else begin
        chk($sformatf("stream%0d_vld", j), dout0_vld, 1'b0);
      end
    end

    // Reset while reads are in flight: flushed, no late strobes, memory kept
    idle(); csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h01; csb1 = 1'b0; addr1 = 8'h02;
    step();
    idle(); csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h03;
    step();
    idle(); rst0 = 1'b1; csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h04;
    step();
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_dout1", dout1, 32'h0);
    idle();
    for (int k = 0; k < int'(RL) + 2; k++) begin
      step();
      chk("flush_vld0", dout0_vld, 1'b0);
      chk("flush_vld1", dout1_vld, 1'b0);
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h01;
    step();
    idle();
    repeat (RL - 1) step();
    chk("post_rst_vld0",  dout0_vld, 1'b1);
    chk("post_rst_dout0", dout0, 32'hA0000001);

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      rst0   = ($urandom_range(0, 49) == 0);
      csb0   = 1'($urandom_range(0, 1));
      web0   = 1'($urandom_range(0, 1));
      wmask0 = 4'($urandom);
      din0   = $urandom;
      addr0  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 199));
      csb1   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) addr1 = addr0;
      else addr1 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 199));
      step();
    end
    idle();
    repeat (RL + 1) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
